// File: rtl/bd2b_pkg.sv
// Shared constants, FSM state type and operand check for the BCD-to-binary converter.
package bd2b_pkg;

  localparam int BCD_W = 12;
  localparam int BIN_W = 8;
  localparam int ITER  = 10;

  typedef enum logic {IDLE, SHIFT} bd2b_state_t;

  // True when every 4-bit digit of the packed operand is a legal BCD digit.
  function automatic logic bcd_valid(logic [BCD_W-1:0] v);
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bd2b_if.sv
// Start/operand request and result/status bundle of the BCD-to-binary converter.
interface bd2b_if;
  import bd2b_pkg::*;

  logic             start;
  logic [BCD_W-1:0] bdc;
  logic [BIN_W-1:0] bc;
  logic             done;
  logic             busy;
  logic             ovf;
  logic             err;

  modport master (output start, bdc, input bc, done, busy, ovf, err);
  modport slave  (input start, bdc, output bc, done, busy, ovf, err);

endinterface

// File: rtl/bd2b_sr_digit_adj.sv
// One BCD column correction of the reverse double-dabble step: columns at 8 or
// above after the right shift carried in a half-weight 10 (worth 5) and lose 3.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bd2b_sr.sv
// Sequential 3-digit BCD to 8-bit binary converter (shift right / subtract 3).
module bd2b_sr
  import bd2b_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic   clk,
  input  logic   rst,
  bd2b_if.slave  bus
);

  localparam int BCDW = 4 * DIGITS;
  localparam int NIT  = $clog2(10 ** DIGITS);
  localparam logic [3:0] LAST = 4'(NIT - 1);

  bd2b_state_t       state, state_n;
  logic [3:0]        cnt;
  logic [BCDW-1:0]   bcd_r;
  logic [NIT-1:0]    bin_r;
  logic [BIN_W-1:0]  bc_r;
  logic              done_r, ovf_r, err_r;

  logic [BCDW+NIT-1:0] sh;
  logic [BCDW-1:0]     bcd_sh, bcd_next;
  logic [NIT-1:0]      bin_next;
  logic                load, step, fin, inval;

  assign sh       = {bcd_r, bin_r} >> 1;
  assign bcd_sh   = sh[BCDW+NIT-1:NIT];
  assign bin_next = sh[NIT-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_sh[4*g +: 4]),
      .q (bcd_next[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-cycle datapath commands; start is ignored outside IDLE.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    inval   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bcd_valid(bus.bdc)) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            inval = 1'b1;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == LAST) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Working register, iteration counter and result registers; the final
  // iteration's post-shift value goes straight to the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      bcd_r  <= '0;
      bin_r  <= '0;
      bc_r   <= '0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load) begin
        bcd_r <= bus.bdc;
        bin_r <= '0;
        cnt   <= '0;
      end
      if (step) begin
        bcd_r <= bcd_next;
        bin_r <= bin_next;
        cnt   <= cnt + 4'd1;
      end
      if (fin) begin
        bc_r   <= bin_next[BIN_W-1:0];
        ovf_r  <= |bin_next[NIT-1:BIN_W];
        err_r  <= 1'b0;
        done_r <= 1'b1;
      end
      if (inval) begin
        bc_r   <= '0;
        ovf_r  <= 1'b0;
        err_r  <= 1'b1;
        done_r <= 1'b1;
      end
    end
  end

  assign bus.bc   = bc_r;
  assign bus.done = done_r;
  assign bus.ovf  = ovf_r;
  assign bus.err  = err_r;
  assign bus.busy = (state == SHIFT);

endmodule

// File: doc/bd2b_sr.md
# bd2b_sr

Sequential BCD-to-binary converter: the reverse direction of the `b2bd_*` binary-to-BCD family. It accepts a 3-digit packed BCD word on a start strobe and runs a shift-right / subtract-3 (reverse double-dabble) loop. It returns the 8-bit binary value with done, overflow and invalid-digit flags. It sits behind any BCD entry path (keypad, display readback) and closes round-trip checks against `b2bd_SR`.

## Interface
- `DIGITS`, default 3: number of BCD digits; BCD width = 4*DIGITS.
- `BIN_W`, default 8: width of the `bc` result.
- `clk` in 1: clock; every flop updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: conversion request; sampled only in IDLE.
- `bdc` in 12: packed BCD operand, digit 2 in [11:8], digit 0 in [3:0]; captured on accepted start.
- `bc` out 8: binary result; held until the next `done`.
- `done` out 1: registered, one-cycle pulse marking a valid new `bc`/`ovf`/`err`.
- `busy` out 1: high while in SHIFT (decoded from the state).
- `ovf` out 1: value exceeds 2^BIN_W-1; `bc` holds the low BIN_W bits.
- `err` out 1: some `bdc` nibble was greater than 9.

## Operation
- The internal working register has two fields:
  - `bcd_r`, 12 bits, and `bin_r`, ITER = 10 bits.
  - ITER is the number of bits needed for 999, which is 10.
  - The two fields are concatenated into one 22-bit register.
- The FSM has two states, IDLE and SHIFT, and an iteration counter `cnt` of 4 bits.
- IDLE with `start`=1 and all nibbles ≤9:
  - load `bcd_r`←`bdc` and `bin_r`←0;
  - set `cnt`←0;
  - go to SHIFT.
- IDLE with `start`=1 and any nibble >9:
  - stay in IDLE;
  - set `bc`←0, `ovf`←0, `err`←1, `done`←1;
  - do not run any iterations.
- Each SHIFT iteration:
  - shift {`bcd_r`,`bin_r`} right by 1;
  - then, in each 4-bit `bcd_r` column, if the value is ≥8, subtract 3;
  - increment `cnt`.
- Last iteration (`cnt`==9):
  - the post-iteration value loads the outputs: `bc`←`bin_next[7:0]`, `ovf`←`|bin_next[9:8]`, `err`←0, `done`←1;
  - the state returns to IDLE.
- `start` while in SHIFT is ignored; there is no queueing.
- `bdc` changes after capture have no effect on the conversion in progress.
- `done` is 0 on every cycle not listed above.
- Reset:
  - state IDLE, `cnt`=0, working register 0;
  - `bc`=0, `done`=0, `ovf`=0, `err`=0, `busy`=0.
- Reset mid-conversion aborts the conversion: no `done` is produced, and the outputs return to their reset values.

## Timing
- Valid operand:
  - `start` sampled at edge N;
  - iterations run at edges N+1 through N+10;
  - `bc`/`ovf`/`done` are updated at edge N+10, so `done` is high during the cycle following edge N+10;
  - latency is 10 clocks.
- `busy` is high in the cycles after edges N through N+9, and low in the cycle in which `done` is high.
- Invalid operand: `done` and `err` are updated at edge N, giving a latency of 1 clock.
- Back-to-back operation: `start` may be high in the same cycle as `done`. It is accepted at edge N+11, and the next `done` follows at edge N+21.
- `rst` has priority over `start` at the same edge.

## Structure
- Package `bd2b_pkg` holds:
  - `BCD_W`=12, `BIN_W`=8, `ITER`=10;
  - `typedef enum logic {IDLE, SHIFT} bd2b_state_t`;
  - a function `bcd_valid(logic [11:0])` that returns 1 when every nibble is ≤9.
- Sub-module `bcd_digit_adj`:
  - combinational, 4-bit input to 4-bit output: output = input ≥8 ? input-3 : input;
  - instantiated DIGITS times on the shifted `bcd_r`.
- The FSM, counter and output registers live in `bd2b_sr`.

## Test plan
- `bdc`=12'h255, `start` pulsed at edge N → `done` at N+10 with `bc`=8'd255 (8'hFF), `ovf`=0, `err`=0; `busy`=1 for 10 cycles.
- `bdc`=12'h256, then 12'h999 → `bc`=8'h00 with `ovf`=1, then `bc`=8'hE7 with `ovf`=1.
- `bdc`=12'h000, then 12'h1A3 → `bc`=0 and `err`=0 after 10 clocks; then `done` at N+1-cycle latency with `err`=1 and `bc`=0.
- Exhaustive round trip:
  - for values 0..255, drive `b2bd_SR` with the value and wait 12 clocks;
  - feed its `bdc` output into this block;
  - check that `bc` equals the original value with `ovf`=0 and `err`=0.
- `start` with 12'h128, `rst` pulsed at cycle 5 of SHIFT → no `done` ever appears; `bc`=0 and `busy`=0 after the reset edge. A subsequent `start` with 12'h128 gives `bc`=8'd128.
- `start` with 12'h042, `start` re-asserted with 12'h077 during SHIFT → one `done` only, `bc`=8'd42. `start` held high across `done` → the second conversion starts at N+11, and its `done` arrives at N+21.
